// File: rtl/palette_lut.sv
// ============================================================================
// palette_lut : programmable indexed-colour palette, pixel index -> {r,g,b}
// Revision    : 1.0
// ============================================================================
`default_nettype none

module palette_lut #(
  parameter int IDX_W = 8,
  parameter int CH_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    pix_idx,
  input  logic                pix_valid,
  output logic [CH_W-1:0]     r,
  output logic [CH_W-1:0]     g,
  output logic [CH_W-1:0]     b,
  output logic                rgb_valid,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_addr,
  input  logic [3*CH_W-1:0]   wr_data,
  output logic                wr_ready,
  input  logic                init_start,
  output logic                init_busy
);

  localparam int DEPTH = 2**IDX_W;
  localparam int ENT_W = 3*CH_W;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q;
  logic               vld_q;
  logic               rgb_vld_q;
  logic [ENT_W-1:0]   rd_q;
  logic [ENT_W-1:0]   mem [DEPTH];

  logic               run;
  logic [CH_W-1:0]    def_ch;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_waddr;
  logic [ENT_W-1:0]   mem_wdata;

  assign run       = (state_q == ST_RUN);
  assign wr_ready  = run;
  assign init_busy = ~run;

  // Default grayscale level: top CH_W index bits, zero-padded when the index is narrower.
  generate
    if (IDX_W >= CH_W) begin : g_def_msb
      assign def_ch = ptr_q[IDX_W-1 -: CH_W];
    end else begin : g_def_pad
      assign def_ch = {ptr_q, {(CH_W-IDX_W){1'b0}}};
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = {def_ch, def_ch, def_ch};
        ptr_d     = ptr_q + IDX_W'(1);
        if (ptr_q == {IDX_W{1'b1}}) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_we = wr_en;
        if (init_start) begin
          state_d = ST_INIT;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      ptr_q     <= '0;
      idx_q     <= '0;
      vld_q     <= 1'b0;
      rgb_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= pix_idx;
      vld_q     <= pix_valid & run;
      rgb_vld_q <= vld_q & run;
    end
  end

  // Reset-free write port and registered read: the read sees pre-write data on a shared edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_q <= mem[idx_q];
  end

  assign rgb_valid = rgb_vld_q;
  assign r = rgb_vld_q ? rd_q[3*CH_W-1 -: CH_W] : '0;
  assign g = rgb_vld_q ? rd_q[2*CH_W-1 -: CH_W] : '0;
  assign b = rgb_vld_q ? rd_q[CH_W-1   -: CH_W] : '0;

endmodule

`default_nettype wire

// File: tb/tb_palette_lut.sv
// ============================================================================
// tb_palette_lut : directed scoreboard bench for palette_lut
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_palette_lut;

  localparam int IDX_W = 8;
  localparam int CH_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [IDX_W-1:0]  pix_idx;
  logic              pix_valid;
  logic [CH_W-1:0]   r, g, b;
  logic              rgb_valid;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [3*CH_W-1:0] wr_data;
  logic              wr_ready;
  logic              init_start;
  logic              init_busy;

  int checks   = 0;
  int failures = 0;

  logic [12:0] exp_q[$];
  logic [12:0] mon_act, mon_exp;
  logic        trk = 1'b0;
  logic        trk_d1 = 1'b0;
  logic        trk_d2 = 1'b0;
  int          cnt;

  palette_lut #(.IDX_W(IDX_W), .CH_W(CH_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_idx    (pix_idx),
    .pix_valid  (pix_valid),
    .r          (r),
    .g          (g),
    .b          (b),
    .rgb_valid  (rgb_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .init_start (init_start),
    .init_busy  (init_busy)
  );

  always #5 clk = ~clk;

  // Tracked pixels emerge two edges after they are registered.
  always @(posedge clk) begin
    trk_d1 <= trk;
    trk_d2 <= trk_d1;
  end

  always @(negedge clk) begin
    if (trk_d2) begin
      mon_act = {rgb_valid, r, g, b};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pix_out: actual %h, required nothing (queue empty)", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL pix_out: actual %h required %h", mon_act, mon_exp);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic pix(input logic [7:0] idx, input logic v, input logic t, input logic [12:0] e);
    pix_idx   = idx;
    pix_valid = v;
    trk       = t;
    if (t) exp_q.push_back(e);
    @(negedge clk);
    trk       = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [11:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    pix_valid  = 1'b0;
    trk        = 1'b0;
    wr_en      = 1'b0;
    init_start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (init_busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pix_idx = '0; pix_valid = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; init_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rgb_valid", rgb_valid, 0);
    check("rst_rgb", {r, g, b}, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_init_busy", init_busy, 1);

    // Power-up ramp load
    rst_n = 1'b1;
    measure_busy(cnt);
    check("init_len", cnt, 256);
    check("run_wr_ready", wr_ready, 1);
    pix(8'hA5, 1'b1, 1'b1, {1'b1, 12'hAAA});
    idle(3);

    // CPU write then lookup; neighbour keeps ramp value
    wr(8'h10, 12'hF0F);
    pix(8'h10, 1'b1, 1'b1, {1'b1, 12'hF0F});
    pix(8'h11, 1'b1, 1'b1, {1'b1, 12'h111});
    idle(3);

    // Blanking alternation
    for (int i = 0; i < 6; i++) begin
      pix(8'hFF, (i % 2 == 0), 1'b1, (i % 2 == 0) ? 13'h1FFF : 13'h0000);
    end
    idle(3);

    // Same-edge read/write: first pixel reads old, second new
    pix(8'h20, 1'b1, 1'b1, {1'b1, 12'h222});
    wr_en = 1'b1; wr_addr = 8'h20; wr_data = 12'h123;
    pix(8'h20, 1'b1, 1'b1, {1'b1, 12'h123});
    wr_en = 1'b0;
    idle(3);

    // Back-to-back writes to one address keep the last
    wr(8'h40, 12'hAAA);
    wr(8'h40, 12'h555);
    pix(8'h40, 1'b1, 1'b1, {1'b1, 12'h555});
    idle(3);

    // Reload: writes and pixels during INIT are dropped / blanked
    wr(8'h30, 12'h000);
    pix(8'h30, 1'b1, 1'b1, {1'b1, 12'h000});
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    cnt = 0;
    while (wr_ready === 1'b0 && cnt < 2000) begin
      if (cnt < 4) begin
        wr_en = 1'b1; wr_addr = 8'h30; wr_data = 12'hABC;
        pix_idx = 8'h30; pix_valid = 1'b1; trk = 1'b1;
        exp_q.push_back(13'h0000);
      end else begin
        wr_en = 1'b0; pix_valid = 1'b0; trk = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    wr_en = 1'b0; pix_valid = 1'b0; trk = 1'b0;
    check("reinit_len", cnt, 256);
    pix(8'h30, 1'b1, 1'b1, {1'b1, 12'h333});
    idle(4);

    // Reset mid-stream clears outputs immediately
    pix_idx = 8'hA5; pix_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stream_valid", rgb_valid, 1);
    check("stream_r", r, 4'hA);
    #3 rst_n = 1'b0;
    #1;
    check("async_rgb_valid", rgb_valid, 0);
    check("async_rgb", {r, g, b}, 0);
    check("async_wr_ready", wr_ready, 0);
    check("async_busy", init_busy, 1);
    @(negedge clk);
    pix_valid = 1'b0;
    rst_n = 1'b1;
    measure_busy(cnt);
    check("post_reset_init_len", cnt, 256);

    // Reset at INIT pointer 100 restarts the full load
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midinit_busy", init_busy, 1);
    check("midinit_rgb_valid", rgb_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    measure_busy(cnt);
    check("midinit_rerun_len", cnt, 256);
    pix(8'h10, 1'b1, 1'b1, {1'b1, 12'h111});
    pix(8'h5C, 1'b1, 1'b1, {1'b1, 12'h555});
    idle(4);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
